// File: rtl/lfsr_4bit.sv
// 4-bit Fibonacci LFSR (x^4+x^3+1) with seed load, period-completion pulse and
// combinational next-value port. Define LFSR_LOCKUP_GUARD_EN to map a zero load to RESET_SEED.
module lfsr_4bit #(
    parameter logic [3:0] RESET_SEED = 4'b0001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       enable,
    input  logic [3:0] inputSeed,
    output logic [3:0] outputRand,
    output logic [3:0] state,
    output logic       periodDone
);

    function automatic logic [3:0] lfsr_step(input logic [3:0] x);
        return {x[2:0], x[3] ^ x[2]};
    endfunction

    logic [3:0] r_state;
    logic [3:0] r_origin;
    logic       r_period_done;
    logic [3:0] w_load_val;
    logic [3:0] w_next_state;

`ifdef LFSR_LOCKUP_GUARD_EN
    // A zero seed would lock the register at 0000; substitute the reset seed.
    assign w_load_val = (inputSeed == 4'b0000) ? RESET_SEED : inputSeed;
`else
    assign w_load_val = inputSeed;
`endif

    assign w_next_state = lfsr_step(r_state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= RESET_SEED;
            r_origin      <= RESET_SEED;
            r_period_done <= 1'b0;
        end else if (load) begin
            r_state       <= w_load_val;
            r_origin      <= w_load_val;
            r_period_done <= 1'b0;
        end else if (enable) begin
            r_state       <= w_next_state;
            r_period_done <= (w_next_state == r_origin);
        end else begin
            r_period_done <= 1'b0;
        end
    end

    assign outputRand = lfsr_step(inputSeed);
    assign state      = r_state;
    assign periodDone = r_period_done;

endmodule

// File: tb/tb_lfsr_4bit.sv
// Directed self-checking bench for lfsr_4bit; expected values are hand-computed constants.
module tb_lfsr_4bit;

    logic       clk;
    logic       reset;
    logic       load;
    logic       enable;
    logic [3:0] inputSeed;
    logic [3:0] outputRand;
    logic [3:0] state;
    logic       periodDone;

    int n_cmp = 0;
    int n_bad = 0;

    lfsr_4bit #(.RESET_SEED(4'b0001)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .enable    (enable),
        .inputSeed (inputSeed),
        .outputRand(outputRand),
        .state     (state),
        .periodDone(periodDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; enable = 1'b0; inputSeed = 4'b0000;
        #2;
        n_cmp++;
        if (state !== 4'b0001 || periodDone !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: state=%b pd=%b, want 0001/0", state, periodDone);
        end
        enable = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (state !== 4'b0001 || periodDone !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_held: state=%b pd=%b, want 0001/0", state, periodDone);
        end
        reset = 1'b0; enable = 1'b0;
        tick();
        n_cmp++;
        if (state !== 4'b0001 || periodDone !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_after_reset: state=%b pd=%b, want 0001/0", state, periodDone);
        end
    endtask

    task automatic test_comb();
        logic [3:0] seeds [4] = '{4'b1110, 4'b1101, 4'b1010, 4'b0100};
        logic [3:0] exps  [4] = '{4'b1100, 4'b1010, 4'b0101, 4'b1001};
        for (int i = 0; i < 4; i++) begin
            inputSeed = seeds[i];
            #20;
            n_cmp++;
            if (outputRand !== exps[i]) begin
                n_bad++;
                $display("FAIL comb[%0d]: in=%b outputRand=%b, want %b",
                         i, seeds[i], outputRand, exps[i]);
            end
        end
    endtask

    task automatic test_sequence();
        logic [3:0] seq [15] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101,
                                 4'b1010, 4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110,
                                 4'b1100, 4'b1000, 4'b0001};
        logic exp_pd;
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            exp_pd = (i == 14);
            n_cmp++;
            if (state !== seq[i] || periodDone !== exp_pd) begin
                n_bad++;
                $display("FAIL seq[%0d]: state=%b pd=%b, want %b/%b",
                         i, state, periodDone, seq[i], exp_pd);
            end
        end
        // periodDone just went high; assert reset mid-cycle and expect immediate clear
        #2;
        inputSeed = 4'b1010;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (state !== 4'b0001 || periodDone !== 1'b0 || outputRand !== 4'b0101) begin
            n_bad++;
            $display("FAIL reset_mid: state=%b pd=%b rand=%b, want 0001/0/0101",
                     state, periodDone, outputRand);
        end
        tick();
        reset = 1'b0;
        tick();
        n_cmp++;
        if (state !== 4'b0010 || periodDone !== 1'b0) begin
            n_bad++;
            $display("FAIL step_after_reset: state=%b pd=%b, want 0010/0", state, periodDone);
        end
        enable = 1'b0;
    endtask

    task automatic test_load();
        logic exp_pd;
        inputSeed = 4'b1110; load = 1'b1; enable = 1'b0;
        tick();
        n_cmp++;
        if (state !== 4'b1110 || periodDone !== 1'b0) begin
            n_bad++;
            $display("FAIL load: state=%b pd=%b, want 1110/0", state, periodDone);
        end
        load = 1'b0; enable = 1'b1;
        tick();
        n_cmp++;
        if (state !== 4'b1100) begin
            n_bad++;
            $display("FAIL load_step1: state=%b, want 1100", state);
        end
        for (int i = 2; i <= 16; i++) begin
            tick();
            exp_pd = (i == 15);
            n_cmp++;
            if (periodDone !== exp_pd) begin
                n_bad++;
                $display("FAIL load_period[%0d]: pd=%b, want %b", i, periodDone, exp_pd);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_load_priority();
        inputSeed = 4'b0110; load = 1'b1; enable = 1'b1;
        tick();
        n_cmp++;
        if (state !== 4'b0110 || periodDone !== 1'b0) begin
            n_bad++;
            $display("FAIL load_priority: state=%b pd=%b, want 0110/0", state, periodDone);
        end
        load = 1'b0; enable = 1'b0;
        tick();
        n_cmp++;
        if (state !== 4'b0110) begin
            n_bad++;
            $display("FAIL hold: state=%b, want 0110", state);
        end
    endtask

    task automatic test_zero_seed();
        inputSeed = 4'b0000; load = 1'b1; enable = 1'b0;
        tick();
        load = 1'b0; enable = 1'b1;
`ifdef LFSR_LOCKUP_GUARD_EN
        n_cmp++;
        if (state !== 4'b0001) begin
            n_bad++;
            $display("FAIL zero_guard_load: state=%b, want 0001", state);
        end
        tick();
        n_cmp++;
        if (state !== 4'b0010 || periodDone !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_guard_step: state=%b pd=%b, want 0010/0", state, periodDone);
        end
`else
        n_cmp++;
        if (state !== 4'b0000 || periodDone !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_load: state=%b pd=%b, want 0000/0", state, periodDone);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (state !== 4'b0000 || periodDone !== 1'b1) begin
                n_bad++;
                $display("FAIL zero_step[%0d]: state=%b pd=%b, want 0000/1",
                         i, state, periodDone);
            end
        end
`endif
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_comb();
        test_sequence();
        test_load();
        test_load_priority();
        test_zero_seed();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
